// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPaused,
    StExpired
  } state_e;

  localparam int unsigned OnesMax = 9;
  localparam int unsigned TensMax = 5;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a borrow-chained down counter; wraps 0 -> MAX and clamps loads to MAX.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int unsigned MAX = OnesMax
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       zero
);

  localparam bcd_digit_t MaxVal = bcd_digit_t'(MAX);

  bcd_digit_t digit_q;
  bcd_digit_t load_clamped;
  bcd_digit_t dec_val;

  assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;
  assign dec_val      = (digit_q == 4'd0) ? MaxVal : digit_q - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (load) begin
      digit_q <= load_clamped;
    end else if (dec_en && borrow_in) begin
      digit_q <= dec_val;
    end
  end

  assign digit      = digit_q;
  assign zero       = (digit_q == 4'd0);
  assign borrow_out = zero & borrow_in;

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: decrements once per tick in RUN and flags expiry at 00:00.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   load_en, dec_en;
  logic   so_zero, st_zero, mo_zero, mt_zero;
  logic   so_borrow, st_borrow, mo_borrow, mt_borrow;
  logic   is_zero, last_sec;

  bcd_down_digit #(.MAX(OnesMax)) u_sec_ones (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .load_val  (load_sec_ones),
    .dec_en    (dec_en),
    .borrow_in (1'b1),
    .digit     (sec_ones),
    .borrow_out(so_borrow),
    .zero      (so_zero)
  );

  bcd_down_digit #(.MAX(TensMax)) u_sec_tens (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .load_val  (load_sec_tens),
    .dec_en    (dec_en),
    .borrow_in (so_borrow),
    .digit     (sec_tens),
    .borrow_out(st_borrow),
    .zero      (st_zero)
  );

  bcd_down_digit #(.MAX(OnesMax)) u_min_ones (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .load_val  (load_min_ones),
    .dec_en    (dec_en),
    .borrow_in (st_borrow),
    .digit     (min_ones),
    .borrow_out(mo_borrow),
    .zero      (mo_zero)
  );

  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk       (clk),
    .reset     (reset),
    .load      (load_en),
    .load_val  (load_min_tens),
    .dec_en    (dec_en),
    .borrow_in (mo_borrow),
    .digit     (min_tens),
    .borrow_out(mt_borrow),
    .zero      (mt_zero)
  );

  assign is_zero  = mt_zero & mo_zero & st_zero & so_zero;
  // The decrement that lands on 00:00 is the one taken from 00:01.
  assign last_sec = mt_zero & mo_zero & st_zero & (sec_ones == 4'd1);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load_en = 1'b0;
    dec_en  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (stop) begin
          state_d = StPaused;
        end else if (tick && !load) begin
          dec_en = 1'b1;
          if (last_sec) begin
            state_d = StExpired;
            done_d  = 1'b1;
          end
        end
      end
      StIdle, StPaused: begin
        if (load) begin
          load_en = 1'b1;
          state_d = StIdle;
        end else if (start && !is_zero) begin
          state_d = StRun;
        end
      end
      StExpired: begin
        if (load) begin
          load_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, stop;
  logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, expired;
  logic [15:0] val;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.MIN_TENS_MAX(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .load         (load),
    .load_min_tens(load_min_tens),
    .load_min_ones(load_min_ones),
    .load_sec_tens(load_sec_tens),
    .load_sec_ones(load_sec_ones),
    .start        (start),
    .stop         (stop),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .running      (running),
    .done         (done),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  assign val = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0000;
    cyc(); cyc();
    check("rst_digits", val, 16'h0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_expired", {15'd0, expired}, 16'd0);
    reset = 1'b0;
    cyc();

    // Asynchronous reset in the middle of a count
    do_load(16'h0317);
    check("load_0317", val, 16'h0317);
    do_start();
    check("run_0317", {15'd0, running}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_digits", val, 16'h0000);
    check("async_rst_running", {15'd0, running}, 16'd0);
    check("async_rst_expired", {15'd0, expired}, 16'd0);
    check("async_rst_done", {15'd0, done}, 16'd0);
    #1 reset = 1'b0;
    cyc();
    check("post_rst_done", {15'd0, done}, 16'd0);

    // 01:00 -> 00:59, tick alongside start is not applied
    do_load(16'h0100);
    check("load_0100", val, 16'h0100);
    start = 1'b1; tick = 1'b1;
    cyc();
    start = 1'b0; tick = 1'b0;
    check("start_tick_ignored", val, 16'h0100);
    check("start_running", {15'd0, running}, 16'd1);
    do_tick();
    check("borrow_0059", val, 16'h0059);
    check("still_running", {15'd0, running}, 16'd1);

    // Expiry from 00:02
    do_stop();
    do_load(16'h0002);
    do_start();
    do_tick();
    check("exp_0001", val, 16'h0001);
    check("exp_no_done_yet", {15'd0, done}, 16'd0);
    idle_cyc();
    do_tick();
    check("exp_0000", val, 16'h0000);
    check("exp_done_pulse", {15'd0, done}, 16'd1);
    check("exp_expired", {15'd0, expired}, 16'd1);
    check("exp_not_running", {15'd0, running}, 16'd0);
    idle_cyc();
    check("exp_done_drop", {15'd0, done}, 16'd0);
    check("exp_expired_hold", {15'd0, expired}, 16'd1);
    do_tick();
    check("exp_no_underflow", val, 16'h0000);
    check("exp_no_second_done", {15'd0, done}, 16'd0);

    // Clamping of non-BCD load values
    do_load(16'h9A7F);
    check("clamp_5959", val, 16'h5959);
    check("clamp_expired_clr", {15'd0, expired}, 16'd0);
    do_start();
    do_tick();
    check("clamp_5958", val, 16'h5958);

    // Pause and resume
    do_stop();
    do_load(16'h1000);
    do_start();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      idle_cyc();
    end
    check("run_0957", val, 16'h0957);
    do_stop();
    check("paused_not_running", {15'd0, running}, 16'd0);
    do_tick();
    do_tick();
    check("paused_hold", val, 16'h0957);
    do_start();
    check("resume_running", {15'd0, running}, 16'd1);
    do_tick();
    check("resume_0956", val, 16'h0956);

    // Load ignored while running
    do_stop();
    do_load(16'h0500);
    do_start();
    do_load(16'h0200);
    check("run_load_ignored", val, 16'h0500);
    check("run_load_running", {15'd0, running}, 16'd1);
    do_tick();
    check("run_0459", val, 16'h0459);

    // Load beats start from PAUSED
    do_stop();
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0200;
    load = 1'b1; start = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    check("load_start_val", val, 16'h0200);
    check("load_start_idle", {15'd0, running}, 16'd0);
    do_tick();
    check("idle_tick_no_effect", val, 16'h0200);

    // Start refused at 00:00
    do_load(16'h0000);
    do_start();
    check("zero_start_val", val, 16'h0000);
    check("zero_start_idle", {15'd0, running}, 16'd0);
    check("zero_start_not_exp", {15'd0, expired}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
